// File: rtl/sbox6_layer_serial_if.sv
// Handshake bundle for sbox6_layer_serial.
// Input channel:  in_valid/in_ready carry in_data (6*NSBOX bits) and the mode bit inv.
// Output channel: out_valid/out_ready carry out_data (6*NSBOX bits).
// slave modport is the S-box layer; master modport is the block feeding/draining it.
interface sbox6_layer_serial_if #(
  parameter int unsigned NSBOX = 8
) ();
  localparam int unsigned W = 6 * NSBOX;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         inv;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;

  modport master (
    output in_valid, in_data, inv, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, inv, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/sbox6_layer_serial.sv
// Iterative S-box layer: applies the fixed 6-bit S-box (or its inverse) to all
// NSBOX slices of the state, LANES slices per clock, lowest slices first.
// Ports:
//   clk  - system clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - slave side of sbox6_layer_serial_if (in_valid/in_ready/in_data/inv,
//          out_valid/out_ready/out_data)
// in_ready is a decode of FSM state and out_ready; every other output is a register.
module sbox6_layer_serial #(
  parameter int unsigned NSBOX = 8,
  parameter int unsigned LANES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  sbox6_layer_serial_if.slave   bus
);

  localparam int unsigned W       = 6 * NSBOX;
  localparam int unsigned G       = NSBOX / LANES;
  localparam int unsigned CW      = (G > 1) ? $clog2(G) : 1;
  localparam int          LANES_I = int'(LANES);

  localparam logic [5:0] SBOX_FWD [64] = '{
    6'd0,  6'd48, 6'd61, 6'd31, 6'd17, 6'd28, 6'd32, 6'd42,
    6'd12, 6'd7,  6'd21, 6'd34, 6'd15, 6'd45, 6'd50, 6'd57,
    6'd43, 6'd44, 6'd51, 6'd14, 6'd30, 6'd19, 6'd1,  6'd35,
    6'd52, 6'd27, 6'd4,  6'd63, 6'd55, 6'd6,  6'd40, 6'd24,
    6'd25, 6'd36, 6'd47, 6'd58, 6'd26, 6'd53, 6'd5,  6'd23,
    6'd11, 6'd41, 6'd18, 6'd54, 6'd38, 6'd2,  6'd62, 6'd9,
    6'd39, 6'd16, 6'd33, 6'd22, 6'd46, 6'd60, 6'd10, 6'd13,
    6'd56, 6'd3,  6'd29, 6'd8,  6'd59, 6'd49, 6'd20, 6'd37
  };

  localparam logic [5:0] SBOX_INV [64] = '{
    6'd0,  6'd22, 6'd45, 6'd57, 6'd26, 6'd38, 6'd29, 6'd9,
    6'd59, 6'd47, 6'd54, 6'd40, 6'd8,  6'd55, 6'd19, 6'd12,
    6'd49, 6'd4,  6'd42, 6'd21, 6'd62, 6'd10, 6'd51, 6'd39,
    6'd31, 6'd32, 6'd36, 6'd25, 6'd5,  6'd58, 6'd20, 6'd3,
    6'd6,  6'd50, 6'd11, 6'd23, 6'd33, 6'd63, 6'd44, 6'd48,
    6'd30, 6'd41, 6'd7,  6'd16, 6'd17, 6'd13, 6'd52, 6'd34,
    6'd1,  6'd61, 6'd14, 6'd18, 6'd24, 6'd37, 6'd43, 6'd28,
    6'd56, 6'd15, 6'd35, 6'd60, 6'd53, 6'd2,  6'd46, 6'd27
  };

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  logic [W-1:0]    r_data;
  logic            r_mode;
  logic [CW-1:0]   r_cnt;
  logic            r_out_valid;

  state_t          w_state_nxt;
  logic [W-1:0]    w_data_nxt;
  logic            w_mode_nxt;
  logic [CW-1:0]   w_cnt_nxt;
  logic            w_in_ready;
  logic [W-1:0]    w_sub;

  // Register with the current group's LANES slices substituted.
  always_comb begin
    w_sub = r_data;
    for (int l = 0; l < LANES_I; l++) begin
      w_sub[(int'(r_cnt) * LANES_I + l) * 6 +: 6] =
        r_mode ? SBOX_INV[r_data[(int'(r_cnt) * LANES_I + l) * 6 +: 6]]
               : SBOX_FWD[r_data[(int'(r_cnt) * LANES_I + l) * 6 +: 6]];
    end
  end

  // Next-state and handshake decode.
  always_comb begin
    w_state_nxt = r_state;
    w_data_nxt  = r_data;
    w_mode_nxt  = r_mode;
    w_cnt_nxt   = r_cnt;
    w_in_ready  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) begin
          w_data_nxt  = bus.in_data;
          w_mode_nxt  = bus.inv;
          w_cnt_nxt   = '0;
          w_state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        w_data_nxt = w_sub;
        if (r_cnt == CW'(G - 1)) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_DONE;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_DONE: begin
        // Consuming the result frees the register, so a waiting block can load on the same edge.
        w_in_ready = bus.out_ready;
        if (bus.out_ready) begin
          if (bus.in_valid) begin
            w_data_nxt  = bus.in_data;
            w_mode_nxt  = bus.inv;
            w_cnt_nxt   = '0;
            w_state_nxt = S_BUSY;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, datapath and registered out_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_data      <= '0;
      r_mode      <= 1'b0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_data      <= w_data_nxt;
      r_mode      <= w_mode_nxt;
      r_cnt       <= w_cnt_nxt;
      r_out_valid <= (w_state_nxt == S_DONE);
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_data;

endmodule

// File: tb/tb_sbox6_layer_serial.sv
// Self-checking bench for sbox6_layer_serial: default (8,2) instance against a
// cycle-level behavioural model, plus (8,8), (8,1), (16,4) instances.
module tb_sbox6_layer_serial;

  localparam int G_MAIN = 4;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;

  int sfwd [64] = '{0,48,61,31,17,28,32,42,12,7,21,34,15,45,50,57,43,44,51,14,30,19,1,35,
                    52,27,4,63,55,6,40,24,25,36,47,58,26,53,5,23,11,41,18,54,38,2,62,9,
                    39,16,33,22,46,60,10,13,56,3,29,8,59,49,20,37};
  int sinv [64];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  sbox6_layer_serial_if #(.NSBOX(8)) bus ();
  sbox6_layer_serial #(.NSBOX(8), .LANES(2)) dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic chk(input string name, input logic [95:0] got, input logic [95:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask

  // Substitute the lowest n slices of d through the table or its inverse.
  function automatic logic [95:0] sub_model(input logic [95:0] d, input logic m, input int n);
    logic [95:0] r;
    r = '0;
    for (int i = 0; i < n; i++) begin
      int v;
      v = int'(d[i*6 +: 6]);
      r[i*6 +: 6] = 6'(m ? sinv[v] : sfwd[v]);
    end
    return r;
  endfunction

  // ---------------- cycle-level model and compare process for the main DUT ----------------
  bit          m_known = 0;
  int          m_busy  = 0;
  bit          m_valid = 0;
  logic [47:0] m_out   = '0;
  logic [47:0] m_res   = '0;

  initial begin
    forever begin
      @(negedge clk);
      if (m_known) begin
        logic exp_ready;
        exp_ready = (m_busy == 0) && (!m_valid || bus.out_ready);
        chk("cyc_in_ready", 96'(bus.in_ready), 96'(exp_ready));
        chk("cyc_out_valid", 96'(bus.out_valid), 96'(m_valid));
        if (m_valid) chk("cyc_out_data", 96'(bus.out_data), 96'(m_out));
      end
      // Advance the model to the state after the coming rising edge.
      if (rst) begin
        m_known = 1; m_busy = 0; m_valid = 0; m_out = '0;
      end else if (m_known) begin
        bit acc;
        acc = bus.in_valid && (m_busy == 0) && (!m_valid || bus.out_ready);
        if (m_valid && bus.out_ready) m_valid = 0;
        if (m_busy > 0) begin
          m_busy--;
          if (m_busy == 0) begin m_valid = 1; m_out = m_res; end
        end
        if (acc) begin
          m_res  = 48'(sub_model(96'(bus.in_data), bus.inv, 8));
          m_busy = G_MAIN;
        end
      end
    end
  end

  // ---------------- parameter sweep instances ----------------
  localparam int SW_N [3] = '{8, 8, 16};
  localparam int SW_L [3] = '{8, 1, 4};
  bit [2:0] sw_done = '0;

  for (genvar k = 0; k < 3; k++) begin : g_sw
    localparam int unsigned N = SW_N[k];
    localparam int unsigned L = SW_L[k];
    localparam int          W = 6 * N;
    localparam int          G = N / L;
    logic srst;
    sbox6_layer_serial_if #(.NSBOX(N)) sif ();
    sbox6_layer_serial #(.NSBOX(N), .LANES(L)) dut_sw (.clk(clk), .rst(srst), .bus(sif));

    initial begin
      logic [95:0] tmp;
      logic        md;
      int          lat;
      srst = 1'b1;
      sif.in_valid = 1'b0; sif.out_ready = 1'b0; sif.inv = 1'b0; sif.in_data = '0;
      repeat (2) @(posedge clk);
      #1 srst = 1'b0;
      for (int b = 0; b < 20; b++) begin
        tmp = {$urandom, $urandom, $urandom};
        md  = 1'($urandom_range(0, 1));
        sif.in_data = tmp[W-1:0]; sif.inv = md; sif.in_valid = 1'b1;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!sif.in_ready && lat < 100);
        @(posedge clk); #1 sif.in_valid = 1'b0;
        lat = 0;
        do begin @(posedge clk); lat++; #1; end while (!sif.out_valid && lat < 64);
        chk($sformatf("sweep%0d_latency", k), 96'(lat), 96'(G));
        chk($sformatf("sweep%0d_data", k), 96'(sif.out_data), sub_model(96'(tmp[W-1:0]), md, int'(N)));
        sif.out_ready = 1'b1;
        @(posedge clk); #1 sif.out_ready = 1'b0;
      end
      sw_done[k] = 1'b1;
    end
  end

  // ---------------- main DUT stimulus ----------------
  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Present a block and return #1 after the edge that accepts it; out_ready drops with it.
  task automatic send(input logic [47:0] d, input logic m);
    int n;
    bus.in_valid = 1'b1; bus.in_data = d; bus.inv = m;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.in_ready && n < 100);
    if (n >= 100) chk("send_timeout", 96'(0), 96'(1));
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    do begin @(posedge clk); lat++; #1; end while (!bus.out_valid && lat < 64);
  endtask

  task automatic consume();
    bus.out_ready = 1'b1;
    tick(1);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    int          lat;
    logic [47:0] d;
    logic [47:0] r;
    logic [47:0] vin;
    logic [47:0] vexp;
    for (int x = 0; x < 64; x++) sinv[sfwd[x]] = x;

    chk("pin_model_fwd", sub_model(96'({8{6'd1}}), 1'b0, 8), 96'({8{6'd48}}));
    chk("pin_model_inv", sub_model(96'({8{6'd37}}), 1'b1, 8), 96'({8{6'd63}}));

    // Reset with in_valid high: nothing may be accepted.
    rst = 1'b1;
    bus.in_valid = 1'b1; bus.in_data = 48'hABCDEF012345; bus.inv = 1'b0; bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_in_ready", 96'(bus.in_ready), 96'(1));
    chk("reset_out_valid", 96'(bus.out_valid), 96'(0));
    chk("reset_out_data", 96'(bus.out_data), 96'(0));
    rst = 1'b0; bus.in_valid = 1'b0;
    tick(1);

    // Forward all-ones, then hold the result under backpressure.
    send({8{6'd1}}, 1'b0);
    wait_out(lat);
    chk("fwd1_latency", 96'(lat), 96'(4));
    chk("fwd1_data", 96'(bus.out_data), 96'({8{6'd48}}));
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("bp_valid", 96'(bus.out_valid), 96'(1));
      chk("bp_data", 96'(bus.out_data), 96'({8{6'd48}}));
      chk("bp_in_ready", 96'(bus.in_ready), 96'(0));
    end

    // Consume and accept the next block on the same edge.
    vin  = {6'd62, 6'd1, 6'd13, 6'd45, 6'd27, 6'd0, 6'd63, 6'd2};
    vexp = {6'd20, 6'd48, 6'd45, 6'd2, 6'd63, 6'd0, 6'd37, 6'd61};
    bus.out_ready = 1'b1;
    send(vin, 1'b0);
    wait_out(lat);
    chk("b2b_latency", 96'(lat), 96'(4));
    chk("vec2_data", 96'(bus.out_data), 96'(vexp));
    consume();

    // Inverse vector.
    send({8{6'd37}}, 1'b1);
    wait_out(lat);
    chk("inv_latency", 96'(lat), 96'(4));
    chk("inv_data", 96'(bus.out_data), 96'({8{6'd63}}));
    consume();
    tick(1);

    // Reset during the second BUSY cycle discards the block.
    send(48'h123456789ABC, 1'b0);
    tick(1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("midrst_in_ready", 96'(bus.in_ready), 96'(1));
    chk("midrst_out_valid", 96'(bus.out_valid), 96'(0));
    for (int i = 0; i < 6; i++) begin
      tick(1);
      chk("midrst_no_valid", 96'(bus.out_valid), 96'(0));
    end
    send(48'h0F1E2D3C4B5A, 1'b1);
    wait_out(lat);
    chk("postrst_latency", 96'(lat), 96'(4));
    chk("postrst_data", 96'(bus.out_data), sub_model(96'(48'h0F1E2D3C4B5A), 1'b1, 8));
    consume();

    // Exhaustive: slice i carries (v + 8*i) mod 64, both modes; data checked by the model.
    for (int v = 0; v < 64; v++) begin
      for (int m = 0; m < 2; m++) begin
        for (int i = 0; i < 8; i++) d[i*6 +: 6] = 6'((v + 8 * i) % 64);
        send(d, 1'(m));
        wait_out(lat);
        chk("exh_latency", 96'(lat), 96'(4));
        consume();
      end
    end

    // Random round trip: forward result fed straight back with inv, back-to-back.
    for (int b = 0; b < 1000; b++) begin
      d = {16'($urandom), $urandom};
      send(d, 1'b0);
      wait_out(lat);
      r = bus.out_data;
      tick($urandom_range(0, 2));
      bus.out_ready = 1'b1;
      send(r, 1'b1);
      wait_out(lat);
      chk("roundtrip", 96'(bus.out_data), 96'(d));
      consume();
    end

    lat = 0;
    while (sw_done != 3'b111 && lat < 5000) begin @(posedge clk); lat++; end
    chk("sweep_done", 96'(sw_done), 96'(3'b111));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
